// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source (alu, lsb, mul), one broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority lsb > alu > mul.
module cdb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
    input  logic [31:0]             alu_value,
    output logic                    alu_ready,
    input  logic                    lsb_valid,
    input  logic [ROB_SIZE_BIT-1:0] lsb_rob_idx,
    input  logic [31:0]             lsb_value,
    output logic                    lsb_ready,
    input  logic                    mul_valid,
    input  logic [ROB_SIZE_BIT-1:0] mul_rob_idx,
    input  logic [31:0]             mul_value,
    output logic                    mul_ready,
    output logic                    cdb_valid,
    output logic [ROB_SIZE_BIT-1:0] cdb_rob_idx,
    output logic [31:0]             cdb_value,
    output logic [1:0]              cdb_src
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_SIZE_BIT + 32;

    logic                         active;
    logic                         flush;
    logic [2:0]                   in_valid;
    logic [2:0][ROB_SIZE_BIT-1:0] in_idx;
    logic [2:0][31:0]             in_val;
    logic [2:0]                   ready_vec;
    logic [2:0]                   push_vec;
    logic [2:0]                   pop_vec;
    logic [2:0]                   nonempty;
    logic [2:0][ENT_W-1:0]        head_ent;
    logic                         grant_any;
    logic [1:0]                   grant_src;

    assign active   = rdy_in && !clear;
    assign flush    = rdy_in && clear;
    assign in_valid = {mul_valid, lsb_valid, alu_valid};
    assign in_idx   = {mul_rob_idx, lsb_rob_idx, alu_rob_idx};
    assign in_val   = {mul_value, lsb_value, alu_value};

    assign alu_ready = ready_vec[0];
    assign lsb_ready = ready_vec[1];
    assign mul_ready = ready_vec[2];

    // Source index order: 0 alu, 1 lsb, 2 mul (matches cdb_src encoding).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;

            // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
            assign ready_vec[gi] = active && (count_reg < CNT_W'(DEPTH));
            assign push_vec[gi]  = in_valid[gi] && ready_vec[gi];
            assign pop_vec[gi]   = grant_any && (grant_src == 2'(gi));
            assign nonempty[gi]  = (count_reg != '0);
            assign head_ent[gi]  = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk_in) begin
                if (push_vec[gi]) begin
                    mem_reg[wr_ptr_reg] <= {in_idx[gi], in_val[gi]};
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in || flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_vec[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop_vec[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push_vec[gi], pop_vec[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

`ifdef CDB_RR_EN
    logic [1:0] last_grant_reg;
    logic [1:0] rr_cand;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    always_comb begin
        grant_any = 1'b0;
        grant_src = 2'd0;
        rr_cand   = next_src(last_grant_reg);
        if (active) begin
            for (int k = 0; k < 3; k++) begin
                if (!grant_any && nonempty[rr_cand]) begin
                    grant_any = 1'b1;
                    grant_src = rr_cand;
                end
                rr_cand = next_src(rr_cand);
            end
        end
    end

    // Reset value 2 makes alu the first source searched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_reg <= 2'd2;
        end else if (flush) begin
            last_grant_reg <= 2'd0;
        end else if (grant_any) begin
            last_grant_reg <= grant_src;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_src = 2'd0;
        if (active) begin
            if (nonempty[1]) begin
                grant_any = 1'b1;
                grant_src = 2'd1;
            end else if (nonempty[0]) begin
                grant_any = 1'b1;
                grant_src = 2'd0;
            end else if (nonempty[2]) begin
                grant_any = 1'b1;
                grant_src = 2'd2;
            end
        end
    end
`endif

    always_comb begin
        cdb_valid   = grant_any;
        cdb_rob_idx = '0;
        cdb_value   = '0;
        cdb_src     = 2'd0;
        if (grant_any) begin
            {cdb_rob_idx, cdb_value} = head_ent[grant_src];
            cdb_src                  = grant_src;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (DEPTH=2); expected values are hand-computed per scenario.
module tb_cdb_arbiter;

    localparam int DEPTH = 2;
    localparam int RB    = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear;
    logic          alu_valid, lsb_valid, mul_valid;
    logic [RB-1:0] alu_rob_idx, lsb_rob_idx, mul_rob_idx;
    logic [31:0]   alu_value, lsb_value, mul_value;
    logic          alu_ready, lsb_ready, mul_ready;
    logic          cdb_valid;
    logic [RB-1:0] cdb_rob_idx;
    logic [31:0]   cdb_value;
    logic [1:0]    cdb_src;

    int n_cmp = 0;
    int n_bad = 0;

    logic [RB-1:0] ord_idx [3];
    logic [1:0]    ord_src [3];
    logic [31:0]   ord_val [3];

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .alu_valid(alu_valid), .alu_rob_idx(alu_rob_idx), .alu_value(alu_value), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_rob_idx(lsb_rob_idx), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
        .mul_valid(mul_valid), .mul_rob_idx(mul_rob_idx), .mul_value(mul_value), .mul_ready(mul_ready),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic v, input logic [RB-1:0] idx,
                             input logic [31:0] val, input logic [1:0] src);
        $display("cdb %s: valid=%0d idx=%0d val=0x%0h src=%0d", tag, cdb_valid, cdb_rob_idx, cdb_value, cdb_src);
        check_eq({tag, ".valid"}, 64'(cdb_valid), 64'(v));
        check_eq({tag, ".idx"},   64'(cdb_rob_idx), 64'(idx));
        check_eq({tag, ".value"}, 64'(cdb_value), 64'(val));
        check_eq({tag, ".src"},   64'(cdb_src), 64'(src));
    endtask

    task automatic check_ready(input string tag, input logic a, input logic l, input logic m);
        check_eq({tag, ".ready"}, 64'({alu_ready, lsb_ready, mul_ready}), 64'({a, l, m}));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; lsb_valid = 1'b0; mul_valid = 1'b0;
        alu_rob_idx = '0; lsb_rob_idx = '0; mul_rob_idx = '0;
        alu_value = '0; lsb_value = '0; mul_value = '0;
    endtask

    task automatic drive_all(input logic [RB-1:0] base);
        alu_valid = 1'b1; alu_rob_idx = base;        alu_value = 32'hA1;
        lsb_valid = 1'b1; lsb_rob_idx = base + 4'd1; lsb_value = 32'hB2;
        mul_valid = 1'b1; mul_rob_idx = base + 4'd2; mul_value = 32'hC3;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; clear = 1'b0; rdy_in = 1'b1;
        idle_inputs();
        step();
        step();
        rst_in = 1'b0;
    endtask

    // Current time is just after a push edge of idx 1/2/3; drain and check arbitration order.
    task automatic drain_three(input string tag);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            settle();
            check_cdb($sformatf("%s.b%0d", tag, k), 1'b1, ord_idx[k], ord_val[k], ord_src[k]);
            step();
        end
        settle();
        check_cdb({tag, ".idle"}, 1'b0, '0, '0, 2'd0);
    endtask

    initial begin
`ifdef CDB_RR_EN
        ord_idx = '{4'd1, 4'd2, 4'd3};
        ord_src = '{2'd0, 2'd1, 2'd2};
        ord_val = '{32'hA1, 32'hB2, 32'hC3};
`else
        ord_idx = '{4'd2, 4'd1, 4'd3};
        ord_src = '{2'd1, 2'd0, 2'd2};
        ord_val = '{32'hB2, 32'hA1, 32'hC3};
`endif
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b1;
        idle_inputs();
        step();
        check_cdb("reset", 1'b0, '0, '0, 2'd0);
        clear = 1'b0;
        step();
        rst_in = 1'b0;
        settle();
        check_ready("after_reset", 1'b1, 1'b1, 1'b1);

        // Single alu result: one-cycle latency, no bypass.
        alu_valid = 1'b1; alu_rob_idx = 4'd3; alu_value = 32'h11;
        settle();
        check_cdb("single.push", 1'b0, '0, '0, 2'd0);
        step();
        idle_inputs();
        settle();
        check_cdb("single.bcast", 1'b1, 4'd3, 32'h11, 2'd0);
        step();
        settle();
        check_cdb("single.idle", 1'b0, '0, '0, 2'd0);

        // Three sources push together.
        do_reset();
        drive_all(4'd1);
        settle();
        check_ready("all3.push", 1'b1, 1'b1, 1'b1);
        step();
        drain_three("all3");

`ifndef CDB_RR_EN
        // lsb keeps the bus busy while alu fills its queue and must hold its third result.
        do_reset();
        alu_valid = 1'b1; alu_rob_idx = 4'd4; alu_value = 32'h40;
        lsb_valid = 1'b1; lsb_rob_idx = 4'd8; lsb_value = 32'h80;
        settle();
        check_ready("sat.c0", 1'b1, 1'b1, 1'b1);
        step();
        alu_rob_idx = 4'd5; alu_value = 32'h50;
        lsb_rob_idx = 4'd9; lsb_value = 32'h90;
        settle();
        check_cdb("sat.c1", 1'b1, 4'd8, 32'h80, 2'd1);
        check_eq("sat.c1.alu_ready", 64'(alu_ready), 64'(1));
        step();
        alu_rob_idx = 4'd6; alu_value = 32'h60;
        lsb_rob_idx = 4'd10; lsb_value = 32'hA0;
        settle();
        check_cdb("sat.c2", 1'b1, 4'd9, 32'h90, 2'd1);
        check_eq("sat.c2.alu_ready", 64'(alu_ready), 64'(0));
        step();
        lsb_valid = 1'b0;
        settle();
        check_cdb("sat.c3", 1'b1, 4'd10, 32'hA0, 2'd1);
        check_eq("sat.c3.alu_ready", 64'(alu_ready), 64'(0));
        step();
        settle();
        check_cdb("sat.c4", 1'b1, 4'd4, 32'h40, 2'd0);
        check_eq("sat.c4.alu_ready", 64'(alu_ready), 64'(0));
        step();
        settle();
        check_cdb("sat.c5", 1'b1, 4'd5, 32'h50, 2'd0);
        check_eq("sat.c5.alu_ready", 64'(alu_ready), 64'(1));
        step();
        alu_valid = 1'b0;
        settle();
        check_cdb("sat.c6", 1'b1, 4'd6, 32'h60, 2'd0);
        step();
        settle();
        check_cdb("sat.idle", 1'b0, '0, '0, 2'd0);
`endif

        // Flush with queued entries and a concurrent push attempt.
        do_reset();
        drive_all(4'd1);
        step();
        step();
        drive_all(4'd7);
        clear = 1'b1;
        settle();
        check_ready("clear.during", 1'b0, 1'b0, 1'b0);
        check_cdb("clear.during", 1'b0, '0, '0, 2'd0);
        step();
        clear = 1'b0;
        idle_inputs();
        settle();
        check_ready("clear.after", 1'b1, 1'b1, 1'b1);
        check_cdb("clear.after", 1'b0, '0, '0, 2'd0);
        step();
        settle();
        check_cdb("clear.empty", 1'b0, '0, '0, 2'd0);

        // Stall for three cycles, with an alu offer that must not be taken.
        do_reset();
        drive_all(4'd1);
        step();
        idle_inputs();
        rdy_in = 1'b0;
        alu_valid = 1'b1; alu_rob_idx = 4'd9; alu_value = 32'h99;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_cdb($sformatf("stall.c%0d", c), 1'b0, '0, '0, 2'd0);
            check_ready($sformatf("stall.c%0d", c), 1'b0, 1'b0, 1'b0);
            step();
        end
        rdy_in = 1'b1;
        drain_three("resume");

        // Reset while queues hold data and clear is high.
        do_reset();
        drive_all(4'd1);
        step();
        step();
        rst_in = 1'b1;
        clear = 1'b1;
        settle();
        check_cdb("rst_flush.during", 1'b0, '0, '0, 2'd0);
        step();
        rst_in = 1'b0;
        clear = 1'b0;
        idle_inputs();
        settle();
        check_cdb("rst_flush.after", 1'b0, '0, '0, 2'd0);
        check_ready("rst_flush.after", 1'b1, 1'b1, 1'b1);
        drive_all(4'd1);
        step();
        drain_three("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
